btn_cmd_encoder: RTL

Front-end for the display-mode controller: takes the two raw display-select pushbuttons, synchronises and debounces each one, and collects press events over a fixed window. Once per window it presents a registered 2-bit command code `in` with a one-cycle strobe `enb2s`. This block drives exactly the code/strobe pair the mode FSM consumes.

---
 rtl/btn_cmd_encoder_pkg.sv | 26 ++
 rtl/btn_cmd_encoder_if.sv | 19 +
 rtl/btn_cmd_encoder_debounce.sv | 50 +++++
 rtl/btn_cmd_encoder.sv | 106 ++++++++++
 4 files changed

// File: rtl/btn_cmd_encoder_pkg.sv
// ----------------------------------------------------------------------------
// disp_pkg : shared types and default constants for btn_cmd_encoder. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package disp_pkg;

   typedef enum logic [1:0] {
      CMD_NONE = 2'b00,
      CMD_F    = 2'b01,
      CMD_C    = 2'b10,
      CMD_BOTH = 2'b11
   } cmd_t;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      ARMED = 2'b01,
      EMIT  = 2'b10
   } latch_state_t;

   localparam int DB_CYCLES_DEF     = 50_000;
   localparam int WINDOW_CYCLES_DEF = 100_000_000;

endpackage

`default_nettype wire

// File: rtl/btn_cmd_encoder_if.sv
// ----------------------------------------------------------------------------
// btn_cmd_encoder_if : raw buttons in, command code and strobe out. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface btn_cmd_encoder_if;
   import disp_pkg::*;

   logic btn_f;
   logic btn_c;
   cmd_t in;
   logic enb2s;

   modport master (output btn_f, output btn_c, input in, input enb2s);
   modport slave  (input btn_f, input btn_c, output in, output enb2s);

endinterface

`default_nettype wire

// File: rtl/btn_cmd_encoder_debounce.sv
// ----------------------------------------------------------------------------
// btn_debounce : two-flop synchroniser, counter debounce, one-cycle press pulse. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module btn_debounce #(
   parameter int DB_CYCLES = 50_000
) (
   input  wire logic clk,
   input  wire logic rst,
   input  wire logic raw,
   output logic      lvl,
   output logic      prs
);

   localparam int DBW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;

   logic           sync1;
   logic           sync2;
   logic           lvl_d;
   logic [DBW-1:0] dbc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         lvl   <= 1'b0;
         lvl_d <= 1'b0;
         prs   <= 1'b0;
         dbc   <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         lvl_d <= lvl;
         prs   <= lvl & ~lvl_d;
         // Any disagreement resets nothing; only agreement clears the run length.
         if (sync2 == lvl) begin
            dbc <= '0;
         end else if (dbc == DBW'(DB_CYCLES - 1)) begin
            lvl <= sync2;
            dbc <= '0;
         end else begin
            dbc <= dbc + 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/btn_cmd_encoder.sv
// ----------------------------------------------------------------------------
// btn_cmd_encoder : debounced button presses collected per window into a strobed code. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module btn_cmd_encoder
   import disp_pkg::*;
#(
   parameter int DB_CYCLES     = DB_CYCLES_DEF,
   parameter int WINDOW_CYCLES = WINDOW_CYCLES_DEF
) (
   input wire logic          clk,
   input wire logic          rst,
   btn_cmd_encoder_if.slave  bus
);

   localparam int WW = $clog2(WINDOW_CYCLES);

   logic [WW-1:0] wcnt;
   logic          tc;
   logic          prs_f;
   logic          prs_c;
   logic [1:0]    prs_vec;
   logic [1:0]    unused_lvl;

   latch_state_t  state;
   latch_state_t  state_n;
   logic [1:0]    pend;
   logic [1:0]    pend_n;
   cmd_t          in_r;
   cmd_t          in_n;
   logic          enb2s_r;
   logic          enb2s_n;

   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_deb_f (
      .clk (clk),
      .rst (rst),
      .raw (bus.btn_f),
      .lvl (unused_lvl[0]),
      .prs (prs_f)
   );

   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_deb_c (
      .clk (clk),
      .rst (rst),
      .raw (bus.btn_c),
      .lvl (unused_lvl[1]),
      .prs (prs_c)
   );

   assign prs_vec = {prs_c, prs_f};
   assign tc      = (wcnt == WW'(WINDOW_CYCLES - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wcnt    <= '0;
         state   <= IDLE;
         pend    <= 2'b00;
         in_r    <= CMD_NONE;
         enb2s_r <= 1'b0;
      end else begin
         wcnt    <= tc ? '0 : wcnt + 1'b1;
         state   <= state_n;
         pend    <= pend_n;
         in_r    <= in_n;
         enb2s_r <= enb2s_n;
      end
   end

   always_comb begin
      state_n = state;
      pend_n  = pend;
      in_n    = in_r;
      enb2s_n = 1'b0;
      case (state)
         IDLE: begin
            pend_n = pend | prs_vec;
            if (prs_vec != 2'b00) state_n = ARMED;
         end
         ARMED: begin
            pend_n = pend | prs_vec;
         end
         EMIT: begin
            // A press landing in the strobe cycle seeds the next window.
            pend_n  = prs_vec;
            state_n = (prs_vec != 2'b00) ? ARMED : IDLE;
         end
         default: begin
            pend_n  = 2'b00;
            state_n = IDLE;
         end
      endcase
      // WINDOW_CYCLES >= 4 keeps tc away from the EMIT cycle.
      if (tc) begin
         in_n    = cmd_t'(pend | prs_vec);
         enb2s_n = 1'b1;
         state_n = EMIT;
      end
   end

   assign bus.in    = in_r;
   assign bus.enb2s = enb2s_r;

endmodule

`default_nettype wire
